// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Optional build macro used by ps2_key_rx: PS2_KEY_RX_TIMEOUT_EN.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_REL = 8'hF0;

    localparam logic [7:0] DISC_00 = 8'h00;
    localparam logic [7:0] DISC_AA = 8'hAA;
    localparam logic [7:0] DISC_EE = 8'hEE;
    localparam logic [7:0] DISC_FA = 8'hFA;
    localparam logic [7:0] DISC_FC = 8'hFC;
    localparam logic [7:0] DISC_FE = 8'hFE;
    localparam logic [7:0] DISC_FF = 8'hFF;

    localparam int KEY_TGL   = 10;
    localparam int KEY_PRESS = 9;
    localparam int KEY_EXT   = 8;
    localparam int KEY_CODE  = 7;

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == DISC_00) || (b == DISC_AA) || (b == DISC_EE) ||
               (b == DISC_FA) || (b == DISC_FC) || (b == DISC_FE) ||
               (b == DISC_FF);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, run-length glitch filter and falling-edge strobe
// for one raw PS/2 line.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver and scancode decoder.
// Define PS2_KEY_RX_TIMEOUT_EN to build the inter-bit stall timeout.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 8000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        err
);
    logic strobe;
    logic dat_lvl;
    logic clk_lvl_unused;
    logic dat_fall_unused;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .level   (clk_lvl_unused),
        .fall    (strobe)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line_in (ps2_dat_in),
        .level   (dat_lvl),
        .fall    (dat_fall_unused)
    );

    ps2_state_e  state, state_n;
    logic [2:0]  bit_cnt, cnt_n;
    logic [7:0]  shreg, sh_n;
    logic        par_bit, par_n;
    logic        ext_f, ext_n;
    logic        rel_f, rel_n;
    logic [10:0] key_n;
    logic        err_n;
    logic        good;

`ifdef PS2_KEY_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo, tmo_n;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ext_f   <= 1'b0;
            rel_f   <= 1'b0;
            ps2_key <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shreg   <= sh_n;
            par_bit <= par_n;
            ext_f   <= ext_n;
            rel_f   <= rel_n;
            ps2_key <= key_n;
            err     <= err_n;
        end
    end

`ifdef PS2_KEY_RX_TIMEOUT_EN
    always_ff @(posedge clk_sys) begin
        if (reset) tmo <= '0;
        else       tmo <= tmo_n;
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        par_n   = par_bit;
        ext_n   = ext_f;
        rel_n   = rel_f;
        key_n   = ps2_key;
        err_n   = 1'b0;
        // Odd weight over data plus parity, and a high stop bit.
        good    = (^{shreg, par_bit}) & dat_lvl;

        unique case (state)
            IDLE: begin
                if (strobe && !dat_lvl) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                if (strobe) begin
                    sh_n  = {dat_lvl, shreg[7:1]};
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (strobe) begin
                    par_n   = dat_lvl;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    state_n = IDLE;
                    unique case (1'b1)
                        !good: begin
                            err_n = 1'b1;
                            ext_n = 1'b0;
                            rel_n = 1'b0;
                        end
                        good && shreg == CODE_EXT: ext_n = 1'b1;
                        good && shreg == CODE_REL: rel_n = 1'b1;
                        good && shreg != CODE_EXT && shreg != CODE_REL &&
                        is_discard(shreg) && !ext_f && !rel_f: ;
                        default: begin
                            key_n = {~ps2_key[KEY_TGL], ~rel_f, ext_f,
                                     shreg};
                            ext_n = 1'b0;
                            rel_n = 1'b0;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef PS2_KEY_RX_TIMEOUT_EN
        tmo_n = '0;
        if (state != IDLE && !strobe) begin
            if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                state_n = IDLE;
                err_n   = 1'b1;
                ext_n   = 1'b0;
                rel_n   = 1'b0;
            end else begin
                tmo_n = tmo + TW'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised frame-level testbench for ps2_key_rx with a behavioural
// scancode model and a per-cycle output compare process.
module tb_ps2_key_rx;

    localparam int FILT_LEN = 8;
    localparam int TMO      = 300;
    localparam int H        = 20;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    ps2_key_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_key    (ps2_key),
        .err        (err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Frame-level model
    logic [10:0] mkey = '0;
    bit          mext = 0;
    bit          mrel = 0;
    logic [10:0] pend_key = '0;
    int          upd_exp = 0, upd_seen = 0;
    int          err_exp = 0, err_seen = 0;
    logic [10:0] cur_key = '0;
    bit          prev_err = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                cur_key  = '0;
                prev_err = 0;
            end else begin
                checks++;
                if (err && (prev_err || err_seen >= err_exp)) begin
                    errors++;
                    $display("FAIL err_pulse err=%b prev=%b seen=%0d exp=%0d",
                             err, prev_err, err_seen, err_exp);
                end
                if (err) err_seen++;
                if (ps2_key !== cur_key) begin
                    checks++;
                    if (upd_seen >= upd_exp || ps2_key !== pend_key) begin
                        errors++;
                        $display("FAIL key_update got=%h exp=%h pending=%0d",
                                 ps2_key, pend_key, upd_exp - upd_seen);
                    end
                    upd_seen++;
                    cur_key = ps2_key;
                end
                prev_err = err;
            end
        end
    endtask

    function automatic bit disc(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

    task automatic predict(input logic [7:0] b, input bit bad_par,
                           input bit bad_stop);
        if (bad_par || bad_stop) begin
            err_exp++;
            mext = 0;
            mrel = 0;
        end else if (b == 8'hE0) begin
            mext = 1;
        end else if (b == 8'hF0) begin
            mrel = 1;
        end else if (!(disc(b) && !mext && !mrel)) begin
            mkey = {~mkey[10], ~mrel, mext, b};
            pend_key = mkey;
            upd_exp++;
            mext = 0;
            mrel = 0;
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b,
                                            input bit bad_par,
                                            input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bit(input logic v, input bit glitch);
        ps2_dat_in = v;
        ps2_clk_in = 1'b1;
        if (glitch) begin
            tick(5);
            ps2_clk_in = 1'b0;
            tick(FILT_LEN - 1);
            ps2_clk_in = 1'b1;
            tick(H - 5 - (FILT_LEN - 1));
        end else begin
            tick(H);
        end
        ps2_clk_in = 1'b0;
        tick(H);
    endtask

    task automatic send_range(input logic [10:0] fr, input int lo,
                              input int hi, input int gl);
        for (int i = lo; i <= hi; i++) send_bit(fr[i], i == gl);
    endtask

    task automatic settle();
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        tick(3 * FILT_LEN + 10);
        chk("update_count", upd_seen, upd_exp);
        chk("err_count", err_seen, err_exp);
        chk("key_vs_model", ps2_key, mkey);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par,
                         input bit bad_stop, input int gl);
        logic [10:0] fr;
        fr = mkframe(b, bad_par, bad_stop);
        send_range(fr, 0, 9, gl);
        predict(b, bad_par, bad_stop);
        send_range(fr, 10, 10, -1);
        settle();
    endtask

    initial begin
        int u0, e0;
        logic [10:0] fr;
        logic [7:0] b;
        logic [7:0] dtab [7];
        dtab = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

        fork
            compare_loop();
        join_none

        tick(4);
        reset = 1'b0;
        tick(2);
        chk("reset_key", ps2_key, 11'h000);
        chk("reset_err", err, 1'b0);

        frame(8'h29, 0, 0, -1);
        chk("make_29", ps2_key, 11'h629);

        u0 = upd_seen;
        frame(8'hF0, 0, 0, -1);
        frame(8'h29, 0, 0, -1);
        chk("break_29", ps2_key, 11'h029);
        chk("break_29_once", upd_seen - u0, 1);

        u0 = upd_seen;
        frame(8'hE0, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h75, 0, 0, -1);
        chk("ext_break_75", ps2_key, 11'h575);
        chk("ext_break_once", upd_seen - u0, 1);
        frame(8'h75, 0, 0, -1);
        chk("make_75", ps2_key, 11'h275);

        e0 = err_seen;
        frame(8'h29, 1, 0, -1);
        chk("bad_par_key", ps2_key, 11'h275);
        chk("bad_par_err", err_seen - e0, 1);
        frame(8'h1C, 0, 0, -1);
        chk("after_err_1c", ps2_key, 11'h61C);

        frame(8'hAA, 0, 0, -1);
        chk("discard_aa", ps2_key, 11'h61C);

        frame(8'h34, 0, 0, 3);
        chk("glitch_34", ps2_key, 11'h234);

        // Abort a frame by reset, with the lines released high.
        fr = mkframe(8'h5A, 0, 0);
        send_range(fr, 0, 3, -1);
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        tick(H);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        mkey = '0;
        mext = 0;
        mrel = 0;
        tick(2);
        chk("mid_reset_key", ps2_key, 11'h000);
        frame(8'h29, 0, 0, -1);
        chk("post_reset_29", ps2_key, 11'h629);

        // Stall after four data bits.
        e0 = err_seen;
        fr = mkframe(8'h3B, 0, 0);
        send_range(fr, 0, 4, -1);
        ps2_clk_in = 1'b1;
`ifdef PS2_KEY_RX_TIMEOUT_EN
        err_exp++;
        mext = 0;
        mrel = 0;
        tick(TMO + 1);
        settle();
        chk("stall_err", err_seen - e0, 1);
`else
        tick(TMO + 1);
        chk("stall_no_err", err_seen - e0, 0);
        send_range(fr, 5, 9, -1);
        predict(8'h3B, 0, 0);
        send_range(fr, 10, 10, -1);
        settle();
`endif
        frame(8'h16, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = dtab[$urandom_range(0, 6)];
            else             b = 8'($urandom);
            frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : -1);
            tick($urandom_range(1, 30));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILT_LEN, default 8: consecutive equal samples needed before a filtered PS/2 line changes level.
REQ-002 Parameter TIMEOUT_CYC, default 8000: idle clk_sys cycles allowed between PS/2 clock falling edges inside a frame (200 us at 40 MHz).
REQ-003 clk_sys  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk_in  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_dat_in  input  1  raw PS/2 data line, asynchronous.
REQ-007 ps2_key  output  11  [10] toggles once per key event, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-008 err  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-009 Each raw line SHALL pass through 2 flip-flop stages, then a filter; filtered level changes only after FILT_LEN consecutive samples at the new level.
REQ-010 A falling edge of the filtered clock SHALL produce a one-cycle sample strobe; filtered data is sampled on that strobe.
REQ-011 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: strobe with data=0 moves to DATA with bit count 0; strobe with data=1 is ignored.
REQ-013 DATA: 8 strobes shift data in LSB first; the 8th strobe moves to PARITY.
REQ-014 PARITY: the strobe captures the parity bit and moves to STOP; data plus parity SHALL have odd weight.
REQ-015 STOP: the strobe returns to IDLE; the byte is valid only if parity is good and stop bit = 1.
REQ-016 Valid 0xE0 SHALL set the ext flag; valid 0xF0 SHALL set the release flag; neither updates ps2_key.
REQ-017 Valid 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE or 0xFF with no prefix flag set SHALL be discarded silently.
REQ-018 Any other valid byte SHALL set ps2_key <= {~ps2_key[10], ~release, ext, byte} on the cycle after the stop strobe, then clear both flags.
REQ-019 Only one ps2_key update SHALL occur per key event, whatever the number of prefixes.
REQ-020 Parity or stop error: err pulses on the cycle after the stop strobe, the byte is dropped, both flags clear, and the FSM enters IDLE.
REQ-021 ps2_key SHALL hold its value between events; err is 0 except for the single-cycle pulse.

Reset
REQ-022 While reset=1 at a clk_sys edge: ps2_key=0, err=0, FSM=IDLE, flags clear, bit count 0, synchroniser and filter outputs forced to 1 (idle high).
REQ-023 Reset mid-frame SHALL abort the frame without a ps2_key change or an err pulse; the next complete frame after release decodes normally.

Configuration
REQ-024 Macro PS2_KEY_RX_TIMEOUT_EN defined: in DATA, PARITY or STOP, TIMEOUT_CYC cycles with no strobe force IDLE, pulse err once and clear both flags; the counter restarts on every strobe.
REQ-025 Macro undefined: no timeout counter is built; a stalled frame is left only on reset or on further strobes.

Structure
REQ-026 Shared package ps2_pkg SHALL hold the FSM state enum, the prefix constants (E0, F0), the discard-code constants and the ps2_key field bit positions.
REQ-027 Sub-module ps2_line_filter (synchroniser, FILT_LEN filter, falling-edge strobe) SHALL be instantiated once per line; only the clock instance's strobe is used.

Verification
REQ-028 From reset, frame 0x29 with good parity -> ps2_key=11'h629 (bit10 0->1); err stays 0.
REQ-029 Frames F0, 29 -> exactly one update: bit10 toggles, [9]=0, [8]=0, [7:0]=0x29.
REQ-030 Frames E0, F0, 75 -> exactly one update: [9]=0, [8]=1, [7:0]=0x75; a following frame 0x75 gives [9]=1, [8]=0.
REQ-031 Frame 0x29 with bad parity -> err high for exactly 1 cycle, ps2_key unchanged; the next good frame 0x1C decodes with [9]=1.
REQ-032 Clock low glitch of FILT_LEN-1 cycles mid-frame -> no extra bit shifted; the frame decodes correctly.
REQ-033 With PS2_KEY_RX_TIMEOUT_EN: 4 data bits then a stall of TIMEOUT_CYC+1 cycles -> one err pulse, FSM IDLE, the next frame decodes; without the macro the same stall gives no err.
